// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the parametrised UART transmitter
// and its future companion receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // 50 MHz / 115200 baud
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

  // Data is zero-extended to 9 bits, so narrower words give the same result.
  function automatic logic parity_bit(input logic [8:0] data, input int unsigned mode);
    logic p;
    p = 1'b0;
    if (mode == PAR_ODD) begin
      p = ~(^data);
    end else if (mode == PAR_EVEN) begin
      p = ^data;
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered full/empty flags and an occupancy output.
// Depth must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wdata,
  input  logic             push,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q;

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (!do_push && do_pop) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == LVL_FULL);
      empty_q <= (level_d == '0);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;

endmodule

// File: rtl/uart_tx_param.sv
// RS-232 transmitter with configurable frame format, frame-aligned bit divider
// and an input FIFO with valid/ready handshake.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("DATA_BITS must be in 5..9");
  end
  if (PARITY > PAR_EVEN) begin : g_bad_parity
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  localparam int unsigned CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] BIT_LAST   = 4'(DATA_BITS - 1);
  localparam logic STOP_LAST        = 1'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 tick;

  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  uart_tx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wdata (tx_data),
    .push  (tx_valid),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    par_d    = par_q;
    fifo_pop = 1'b0;
    if (state_q != StIdle) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        // Holding the divider at zero aligns every frame to its start bit.
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          par_d    = parity_bit(9'(fifo_rdata), PARITY);
          state_d  = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY != PAR_NONE) ? StParity : StStop;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          state_d = StStop;
          stop_d  = 1'b0;
        end
      end
      StStop: begin
        if (tick) begin
          if (stop_q == STOP_LAST) begin
            state_d = StIdle;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_q[0];
      StParity: txd_d = par_q;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  assign txd      = txd_q;
  assign tx_ready = ~fifo_full;
  assign tx_busy  = (state_q != StIdle) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench: four transmitter configurations, a line receiver feeding
// a frame queue, and per-scenario tasks comparing against an expected queue.
module tb_uart_tx_param;
  import uart_pkg::*;

  localparam int unsigned CPB = 4;

  typedef struct {
    logic [8:0]  data;
    logic        par;
    logic        stop_ok;
    int unsigned start;
  } frame_t;

  typedef struct {
    logic [8:0] data;
    logic       par;
  } exp_t;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic [7:0]  tb_data  = '0;
  logic        tb_valid = 1'b0;
  int unsigned sel      = 0;
  int unsigned cfg_db   = 8;
  int unsigned cfg_par  = 0;
  int unsigned cfg_stop = 1;
  int unsigned cyc      = 0;
  int          checks   = 0;
  int          errors   = 0;

  logic [3:0] valid_v, ready_v, txd_v, busy_v;
  logic [2:0] level_v [4];
  logic       txd_sel, ready_sel, busy_sel;
  logic [2:0] level_sel;

  frame_t rx_q[$];
  exp_t   exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 4; k++) begin : g_valid
    assign valid_v[k] = tb_valid && (sel == k);
  end

  always_comb begin
    txd_sel   = txd_v[sel[1:0]];
    ready_sel = ready_v[sel[1:0]];
    busy_sel  = busy_v[sel[1:0]];
    level_sel = level_v[sel[1:0]];
  end

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7E2
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) u_dut_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tb_data), .tx_valid(valid_v[0]), .tx_ready(ready_v[0]),
    .txd(txd_v[0]), .tx_busy(busy_v[0]), .fifo_level(level_v[0]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) u_dut_8e1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tb_data), .tx_valid(valid_v[1]), .tx_ready(ready_v[1]),
    .txd(txd_v[1]), .tx_busy(busy_v[1]), .fifo_level(level_v[1]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) u_dut_8o1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tb_data), .tx_valid(valid_v[2]), .tx_ready(ready_v[2]),
    .txd(txd_v[2]), .tx_busy(busy_v[2]), .fifo_level(level_v[2]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(2),
                  .FIFO_DEPTH(4)) u_dut_7e2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tb_data[6:0]), .tx_valid(valid_v[3]),
    .tx_ready(ready_v[3]), .txd(txd_v[3]), .tx_busy(busy_v[3]), .fifo_level(level_v[3]));

  // Line receiver: samples mid-bit on falling edges and records frames only.
  initial begin : rx_monitor
    frame_t f;
    forever begin
      @(negedge clk);
      if (rst_n && txd_sel === 1'b0) begin
        f.start   = cyc;
        f.data    = '0;
        f.par     = 1'b0;
        f.stop_ok = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < int'(cfg_db); i++) begin
          repeat (CPB) @(negedge clk);
          f.data[i] = txd_sel;
        end
        if (cfg_par != 0) begin
          repeat (CPB) @(negedge clk);
          f.par = txd_sel;
        end
        for (int s = 0; s < int'(cfg_stop); s++) begin
          repeat (CPB) @(negedge clk);
          if (txd_sel !== 1'b1) f.stop_ok = 1'b0;
        end
        rx_q.push_back(f);
      end
    end
  end

  task automatic select_dut(input int unsigned k);
    sel      = k;
    cfg_db   = (k == 3) ? 7 : 8;
    cfg_par  = (k == 1 || k == 3) ? 2 : ((k == 2) ? 1 : 0);
    cfg_stop = (k == 3) ? 2 : 1;
    #1;
  endtask

  task automatic send_one(input logic [7:0] d, input logic p);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (ready_sel !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready_sel === 1'b1) begin
      tb_data  = d;
      tb_valid = 1'b1;
      e.data   = 9'(d);
      e.par    = p;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      tb_valid = 1'b0;
    end
  endtask

  task automatic wait_rx(input int n, input int budget, output logic ok);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      select_dut(k);
      checks++;
      if (txd_sel !== 1'b1 || ready_sel !== 1'b1 || busy_sel !== 1'b0 || level_sel !== 3'd0) begin
        errors++;
        $display("FAIL reset_values dut%0d got txd=%b ready=%b busy=%b level=%0d want 1 1 0 0",
                 k, txd_sel, ready_sel, busy_sel, level_sel);
      end
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    select_dut(0);
  endtask

  task automatic test_frame_8n1();
    logic [9:0] bits;
    exp_t       e;
    frame_t     r;
    logic       ok;
    bits = {1'b1, 8'h55, 1'b0};
    select_dut(0);
    @(negedge clk);
    checks++;
    if (ready_sel !== 1'b1 || busy_sel !== 1'b0) begin
      errors++;
      $display("FAIL idle_8n1 got ready=%b busy=%b want ready=1 busy=0", ready_sel, busy_sel);
    end
    tb_data  = 8'h55;
    tb_valid = 1'b1;
    e.data   = 9'h055;
    e.par    = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    tb_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (txd_sel !== 1'b1 || busy_sel !== 1'b1) begin
      errors++;
      $display("FAIL latency_8n1 got txd=%b busy=%b want txd=1 busy=1", txd_sel, busy_sel);
    end
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      checks++;
      if (txd_sel !== bits[j / CPB]) begin
        errors++;
        $display("FAIL bit_8n1 cycle %0d got txd=%b want %b", j, txd_sel, bits[j / CPB]);
      end
      if (j >= 38) begin
        checks++;
        if (busy_sel !== (j == 38)) begin
          errors++;
          $display("FAIL busy_8n1 cycle %0d got %b want %b", j, busy_sel, (j == 38));
        end
      end
    end
    @(negedge clk);
    checks++;
    if (txd_sel !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_8n1 got txd=%b want 1", txd_sel);
    end
    wait_rx(1, 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rx_timeout_8n1 got %0d frames want 1", rx_q.size());
    end
    while (exp_q.size() != 0 && rx_q.size() != 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r.data !== e.data || r.stop_ok !== 1'b1) begin
        errors++;
        $display("FAIL sb_8n1 got data=%h stop=%b want data=%h stop=1", r.data, r.stop_ok, e.data);
      end
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic test_parity();
    exp_t   e;
    frame_t r;
    logic   ok;
    select_dut(1);
    repeat (3) @(negedge clk);
    send_one(8'h07, 1'b1);
    wait_rx(1, 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rx_timeout_even got %0d frames want 1", rx_q.size());
    end
    repeat (4) @(negedge clk);
    select_dut(2);
    send_one(8'h07, 1'b0);
    send_one(8'h00, 1'b1);
    wait_rx(3, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rx_timeout_odd got %0d frames want 3", rx_q.size());
    end else begin
      checks++;
      if (rx_q[2].start - rx_q[1].start != 45) begin
        errors++;
        $display("FAIL gap_odd got %0d want 45", rx_q[2].start - rx_q[1].start);
      end
    end
    while (exp_q.size() != 0 && rx_q.size() != 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r.data !== e.data || r.par !== e.par || r.stop_ok !== 1'b1) begin
        errors++;
        $display("FAIL sb_parity got data=%h par=%b stop=%b want data=%h par=%b stop=1",
                 r.data, r.par, r.stop_ok, e.data, e.par);
      end
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic test_frame_7e2();
    logic [10:0] bits;
    exp_t        e;
    frame_t      r;
    logic        ok;
    bits = {2'b11, 1'b0, 7'h41, 1'b0};
    repeat (4) @(negedge clk);
    select_dut(3);
    @(negedge clk);
    tb_data  = 8'h41;
    tb_valid = 1'b1;
    e.data   = 9'h041;
    e.par    = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    tb_valid = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 44; j++) begin
      @(negedge clk);
      checks++;
      if (txd_sel !== bits[j / CPB]) begin
        errors++;
        $display("FAIL bit_7e2 cycle %0d got txd=%b want %b", j, txd_sel, bits[j / CPB]);
      end
      if (j >= 42) begin
        checks++;
        if (busy_sel !== (j == 42)) begin
          errors++;
          $display("FAIL busy_7e2 cycle %0d got %b want %b", j, busy_sel, (j == 42));
        end
      end
    end
    wait_rx(1, 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rx_timeout_7e2 got %0d frames want 1", rx_q.size());
    end
    while (exp_q.size() != 0 && rx_q.size() != 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r.data !== e.data || r.par !== e.par || r.stop_ok !== 1'b1) begin
        errors++;
        $display("FAIL sb_7e2 got data=%h par=%b stop=%b want data=%h par=%b stop=1",
                 r.data, r.par, r.stop_ok, e.data, e.par);
      end
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic test_back_to_back();
    exp_t   e;
    frame_t r;
    logic   ok;
    logic   saw_full;
    int     i;
    int     guard;
    saw_full = 1'b0;
    i        = 0;
    guard    = 0;
    repeat (4) @(negedge clk);
    select_dut(0);
    @(negedge clk);
    tb_valid = 1'b1;
    tb_data  = 8'd1;
    while (i < 6 && guard < 400) begin
      checks++;
      if (level_sel == 3'd4) begin
        saw_full = 1'b1;
        if (ready_sel !== 1'b0) begin
          errors++;
          $display("FAIL ready_full got %b want 0", ready_sel);
        end
      end else if (ready_sel !== 1'b1) begin
        errors++;
        $display("FAIL ready_not_full level=%0d got %b want 1", level_sel, ready_sel);
      end
      if (ready_sel === 1'b1) begin
        e.data = 9'(tb_data);
        e.par  = 1'b0;
        exp_q.push_back(e);
        i++;
      end
      @(posedge clk);
      @(negedge clk);
      tb_data = 8'(i + 1);
      guard++;
    end
    tb_valid = 1'b0;
    checks++;
    if (saw_full !== 1'b1) begin
      errors++;
      $display("FAIL fifo_reached_full got %b want 1", saw_full);
    end
    wait_rx(6, 6 * 45 + 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rx_timeout_b2b got %0d frames want 6", rx_q.size());
    end else begin
      for (int k = 1; k < 6; k++) begin
        checks++;
        if (rx_q[k].start - rx_q[k-1].start != 41) begin
          errors++;
          $display("FAIL gap_b2b frame %0d got %0d want 41", k, rx_q[k].start - rx_q[k-1].start);
        end
      end
    end
    while (exp_q.size() != 0 && rx_q.size() != 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r.data !== e.data || r.stop_ok !== 1'b1) begin
        errors++;
        $display("FAIL sb_b2b got data=%h stop=%b want data=%h stop=1", r.data, r.stop_ok, e.data);
      end
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic test_push_pop_same_edge();
    exp_t   e;
    frame_t r;
    logic   ok;
    repeat (4) @(negedge clk);
    select_dut(0);
    e.par = 1'b0;
    @(negedge clk);
    tb_data  = 8'hA1;
    tb_valid = 1'b1;
    e.data   = 9'h0A1;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    tb_valid = 1'b0;
    repeat (4) @(negedge clk);
    tb_data  = 8'hB2;
    tb_valid = 1'b1;
    e.data   = 9'h0B2;
    exp_q.push_back(e);
    @(negedge clk);
    tb_data = 8'hC3;
    e.data  = 9'h0C3;
    exp_q.push_back(e);
    @(negedge clk);
    tb_valid = 1'b0;
    checks++;
    if (level_sel !== 3'd2) begin
      errors++;
      $display("FAIL level_filled got %0d want 2", level_sel);
    end
    repeat (35) @(negedge clk);
    checks++;
    if (level_sel !== 3'd2 || busy_sel !== 1'b1) begin
      errors++;
      $display("FAIL level_before_pop got level=%0d busy=%b want 2 1", level_sel, busy_sel);
    end
    tb_data  = 8'hD4;
    tb_valid = 1'b1;
    e.data   = 9'h0D4;
    exp_q.push_back(e);
    @(negedge clk);
    tb_valid = 1'b0;
    checks++;
    if (level_sel !== 3'd2) begin
      errors++;
      $display("FAIL level_push_pop got %0d want 2", level_sel);
    end
    wait_rx(4, 4 * 41 + 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rx_timeout_pushpop got %0d frames want 4", rx_q.size());
    end
    while (exp_q.size() != 0 && rx_q.size() != 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r.data !== e.data || r.stop_ok !== 1'b1) begin
        errors++;
        $display("FAIL sb_pushpop got data=%h stop=%b want data=%h stop=1",
                 r.data, r.stop_ok, e.data);
      end
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    exp_t   e;
    frame_t r;
    logic   ok;
    repeat (4) @(negedge clk);
    select_dut(0);
    @(negedge clk);
    tb_data  = 8'hF0;
    tb_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_data = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    tb_valid = 1'b0;
    // Now one cycle after the pop edge; data bit 3 occupies the line 18..21 cycles after accept.
    repeat (18) @(negedge clk);
    checks++;
    if (txd_sel !== 1'b0 || level_sel !== 3'd1) begin
      errors++;
      $display("FAIL pre_reset got txd=%b level=%0d want txd=0 level=1", txd_sel, level_sel);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (txd_sel !== 1'b1 || ready_sel !== 1'b1 || level_sel !== 3'd0 || busy_sel !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got txd=%b ready=%b level=%0d busy=%b want 1 1 0 0",
               txd_sel, ready_sel, level_sel, busy_sel);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    rx_q.delete();
    exp_q.delete();
    repeat (50) @(negedge clk);
    checks++;
    if (rx_q.size() != 0 || busy_sel !== 1'b0 || txd_sel !== 1'b1) begin
      errors++;
      $display("FAIL no_resume got frames=%0d busy=%b txd=%b want 0 0 1",
               rx_q.size(), busy_sel, txd_sel);
    end
    send_one(8'hA5, 1'b0);
    wait_rx(1, 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rx_timeout_after_reset got %0d frames want 1", rx_q.size());
    end
    while (exp_q.size() != 0 && rx_q.size() != 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r.data !== e.data || r.stop_ok !== 1'b1) begin
        errors++;
        $display("FAIL sb_after_reset got data=%h stop=%b want data=%h stop=1",
                 r.data, r.stop_ok, e.data);
      end
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_frame_8n1();
    test_parity();
    test_frame_7e2();
    test_back_to_back();
    test_push_pop_same_edge();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
